// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encoding and FSM states.
package onehot_scan_decoder_pkg;

  // Value of the mode input selecting each operating mode
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Controller states; IDLE is the reset and disabled state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10
  } state_e;

endpackage

// File: rtl/onehot_scan_decoder_dec.sv
// Combinational AW -> 2**AW one-hot decoder with enable; all-zero when disabled.
module onehot_dec #(
  parameter int AW = 3
) (
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  output logic [(2**AW)-1:0]   y
);

  // Exactly one bit set at position addr when enabled, otherwise idle
  always_comb begin
    y = '0;
    if (en) begin
      y[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with DIRECT (decode addr) and SCAN (auto-step with dwell) modes.
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int AW      = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [AW-1:0]        addr,
  input  logic                 load,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(2**AW)-1:0]   y,
  output logic [AW-1:0]        idx,
  output logic                 wrap
);

  localparam logic [AW-1:0] IDX_MAX = {AW{1'b1}};

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic [(2**AW)-1:0]   y_q, y_d;

  logic                 dec_en;
  logic [AW-1:0]        dec_addr;

  // Next-state logic: disable beats mode, mode entry/load beats dwell countdown
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    dec_en   = 1'b0;
    dec_addr = idx_q;

    if (!en) begin
      // Outputs go idle; idx keeps its last value so software can still read it
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (mode == MODE_DIRECT) begin
      state_d  = ST_DIRECT;
      idx_d    = addr;
      cnt_d    = '0;
      dec_en   = 1'b1;
      dec_addr = addr;
    end else begin
      state_d = ST_SCAN;
      dec_en  = 1'b1;
      if ((state_q != ST_SCAN) || load) begin
        // Entry into SCAN or explicit restart: jump to addr, never a wrap
        idx_d = addr;
        cnt_d = dwell;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else begin
        // Dwell expired: advance with natural AW-bit wrap, reload dwell
        idx_d  = idx_q + AW'(1);
        cnt_d  = dwell;
        wrap_d = (idx_q == IDX_MAX);
      end
      dec_addr = idx_d;
    end
  end

  onehot_dec #(
    .AW (AW)
  ) u_dec (
    .en   (dec_en),
    .addr (dec_addr),
    .y    (y_d)
  );

  // State, index, dwell counter and outputs; async clear to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder at AW=3 with AW=1 and AW=4 instances sharing stimulus.
module tb_onehot_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [2:0]  addr;
  logic        load;
  logic [7:0]  dwell;

  logic [7:0]  y3;
  logic [2:0]  idx3;
  logic        wrap3;

  logic        addr1;
  logic [1:0]  y1;
  logic        idx1;
  logic        wrap1;

  logic [3:0]  addr4;
  logic [15:0] y4;
  logic [3:0]  idx4;
  logic        wrap4;

  int errors = 0;
  int checks = 0;

  assign addr1 = addr[0];
  assign addr4 = {addr[0], addr};

  onehot_scan_decoder #(.AW(3), .DWELL_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
    .dwell(dwell), .y(y3), .idx(idx3), .wrap(wrap3)
  );

  onehot_scan_decoder #(.AW(1), .DWELL_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr1), .load(load),
    .dwell(dwell), .y(y1), .idx(idx1), .wrap(wrap1)
  );

  onehot_scan_decoder #(.AW(4), .DWELL_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr4), .load(load),
    .dwell(dwell), .y(y4), .idx(idx4), .wrap(wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sweep_y [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] scan_y  [10] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80,
                               8'h01, 8'h01, 8'h01, 8'h02};
  logic       scan_w  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0] step_i  [7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards verify the one-hot invariant on every instance if enabled at the edge
  task automatic step();
    logic live;
    logic [31:0] e3, e1, e4;
    live = en && rst_n;
    @(posedge clk);
    #1;
    if (live) begin
      e3 = 32'd1 << idx3;
      e1 = 32'd1 << idx1;
      e4 = 32'd1 << idx4;
      chk("inv_onehot3", 32'($onehot(y3)), 32'd1);
      chk("inv_y_idx3", {24'd0, y3}, e3);
      chk("inv_onehot1", 32'($onehot(y1)), 32'd1);
      chk("inv_y_idx1", {30'd0, y1}, e1);
      chk("inv_onehot4", 32'($onehot(y4)), 32'd1);
      chk("inv_y_idx4", {16'd0, y4}, e4);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                      input logic ew);
    chk({tag, "_y"}, {24'd0, y3}, {24'd0, ey});
    chk({tag, "_idx"}, {29'd0, idx3}, {29'd0, ei});
    chk({tag, "_wrap"}, {31'd0, wrap3}, {31'd0, ew});
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    addr  = 3'd0;
    load  = 1'b0;
    dwell = 8'd0;

    // Reset state
    step();
    step();
    chk3("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk3("idle_after_reset", 8'h00, 3'd0, 1'b0);

    // DIRECT decode with one-clock latency
    en = 1'b1; mode = 1'b0; addr = 3'd5;
    step();
    chk3("direct5", 8'h20, 3'd5, 1'b0);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      step();
      chk3("direct_sweep", sweep_y[a], 3'(a), 1'b0);
    end

    // SCAN with dwell=2 starting at 6: three clocks per index, wrap on 7->0
    mode = 1'b1; dwell = 8'd2; addr = 3'd6;
    step();
    addr = 3'd1;
    chk3("scan_d2_0", scan_y[0], 3'd6, scan_w[0]);
    for (int k = 1; k < 10; k++) begin
      step();
      chk({"scan_d2_y"}, {24'd0, y3}, {24'd0, scan_y[k]});
      chk({"scan_d2_wrap"}, {31'd0, wrap3}, {31'd0, scan_w[k]});
    end
    for (int k = 0; k < 20; k++) step();
    chk3("scan_d2_prewrap", 8'h80, 3'd7, 1'b0);
    step();
    chk3("scan_d2_wrap2", 8'h01, 3'd0, 1'b1);

    // SCAN with dwell=0: load restarts, steps every clock, wraps once per 8
    dwell = 8'd0; load = 1'b1; addr = 3'd0;
    step();
    load = 1'b0;
    chk3("d0_load0", 8'h01, 3'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk3("d0_step", sweep_y[step_i[k]], step_i[k], 1'b0);
    end
    step();
    chk3("d0_wrap", 8'h01, 3'd0, 1'b1);
    for (int k = 0; k < 7; k++) step();
    chk3("d0_at7", 8'h80, 3'd7, 1'b0);
    load = 1'b1; addr = 3'd3;
    step();
    load = 1'b0;
    chk3("d0_load3_nowrap", 8'h08, 3'd3, 1'b0);
    step();
    chk3("d0_after_load", 8'h10, 3'd4, 1'b0);

    // Disable at idx=4, then re-enable restarts at addr with the new dwell
    en = 1'b0;
    step();
    chk3("dis_1", 8'h00, 3'd4, 1'b0);
    step();
    chk3("dis_2", 8'h00, 3'd4, 1'b0);
    en = 1'b1; dwell = 8'd3; addr = 3'd2;
    step();
    chk3("reen_0", 8'h04, 3'd2, 1'b0);
    step();
    step();
    step();
    chk3("reen_3", 8'h04, 3'd2, 1'b0);
    step();
    chk3("reen_4", 8'h08, 3'd3, 1'b0);

    // Mode toggling SCAN -> DIRECT -> SCAN -> DIRECT
    mode = 1'b0; addr = 3'd5;
    step();
    chk3("m_direct5", 8'h20, 3'd5, 1'b0);
    addr = 3'd1;
    step();
    chk3("m_direct1", 8'h02, 3'd1, 1'b0);
    mode = 1'b1; addr = 3'd6; dwell = 8'd0;
    step();
    chk3("m_scan6", 8'h40, 3'd6, 1'b0);
    step();
    chk3("m_scan7", 8'h80, 3'd7, 1'b0);
    step();
    chk3("m_scan0", 8'h01, 3'd0, 1'b1);
    mode = 1'b0; addr = 3'd3;
    step();
    chk3("m_direct3", 8'h08, 3'd3, 1'b0);
    load = 1'b1; addr = 3'd4;
    step();
    load = 1'b0;
    chk3("m_direct_load_ign", 8'h10, 3'd4, 1'b0);

    // Asynchronous reset mid-scan, no clock edge needed
    mode = 1'b1; dwell = 8'd1; addr = 3'd2;
    step();
    chk3("pre_rst", 8'h04, 3'd2, 1'b0);
    step();
    rst_n = 1'b0;
    #2;
    chk3("async_rst", 8'h00, 3'd0, 1'b0);
    en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk3("rst_hold_idle", 8'h00, 3'd0, 1'b0);
    en = 1'b1; addr = 3'd5;
    step();
    chk3("rst_restart", 8'h20, 3'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
